banked_serial_lut: RTL and testbench

- Multi-bank, serially loaded lookup table with a double-buffered shadow register and frame-length checking.
- A frame of exactly `2**IN_WIDTH*OUT_WIDTH` bits is shifted into the shadow register while `cs_n` is low. When `cs_n` deasserts, a valid frame is committed atomically into one of `BANKS` active tables.
- Lookups select a bank and an entry, and return a registered output.
- Successor to the single-table serial LUT: adds banking, atomic commit, error detection, and optional daisy-chain readback.

---
 rtl/banked_serial_lut_pkg.sv | 20 ++
 rtl/banked_serial_lut_frame_rx.sv | 144 ++++++++++++++
 rtl/banked_serial_lut.sv | 100 ++++++++++
 tb/tb_banked_serial_lut.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/banked_serial_lut_pkg.sv
// Shared types and sizing helpers for the banked serial LUT.
// The optional readback path is enabled by BANKED_SERIAL_LUT_READBACK_EN.
package banked_serial_lut_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } rx_state_e;

  function automatic int table_bits(input int in_w, input int out_w);
    return (1 << in_w) * out_w;
  endfunction

  // Bank index width; a single bank still gets a 1-bit index port.
  function automatic int bank_idx_w(input int banks);
    return (banks > 1) ? $clog2(banks) : 1;
  endfunction

endpackage

// File: rtl/banked_serial_lut_frame_rx.sv
// Serial frame receiver: shadow shift register, length counter, commit FSM.
// Readback on dout exists only when BANKED_SERIAL_LUT_READBACK_EN is defined.
module serial_frame_rx
  import banked_serial_lut_pkg::*;
#(
  parameter int IN_WIDTH  = 3,
  parameter int OUT_WIDTH = 8,
  parameter int BANKS     = 2,
  localparam int TB       = table_bits(IN_WIDTH, OUT_WIDTH),
  localparam int BANK_W   = bank_idx_w(BANKS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              d,
  input  logic [BANK_W-1:0] wr_bank,
  output logic              commit_pulse,
  output logic [BANK_W-1:0] tgt,
  output logic [TB-1:0]     shadow,
  output logic              frame_err,
  output logic              dout
);

  localparam int CNT_W = $clog2(TB + 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TB);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TB + 1);

  rx_state_e         state_q, state_d;
  logic [TB-1:0]     shadow_q, shadow_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BANK_W-1:0] tgt_q, tgt_d;
  logic              err_q, err_d;
  logic              commit_q, commit_d;
  logic              shift_s;
  logic              tgt_ok_s;

  if (BANKS == (1 << BANK_W)) begin : g_tgt_full
    assign tgt_ok_s = 1'b1;
  end else begin : g_tgt_part
    assign tgt_ok_s = (tgt_q < BANK_W'(BANKS));
  end

  // Next-state logic; COMMIT deliberately ignores cs_n so a frame only starts from IDLE.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tgt_d    = tgt_q;
    err_d    = err_q;
    commit_d = 1'b0;
    shift_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!cs_n) begin
          shift_s = 1'b1;
          cnt_d   = CNT_ONE;
          tgt_d   = wr_bank;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (!cs_n) begin
          shift_s = 1'b1;
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end else if ((cnt_q == CNT_FULL) && tgt_ok_s) begin
          state_d  = COMMIT;
          commit_d = 1'b1;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      COMMIT: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (shift_s) begin
      shadow_d = {shadow_q[TB-2:0], d};
    end else begin
      shadow_d = shadow_q;
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= {TB{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      tgt_q    <= {BANK_W{1'b0}};
      err_q    <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      tgt_q    <= tgt_d;
      err_q    <= err_d;
      commit_q <= commit_d;
    end
  end

`ifdef BANKED_SERIAL_LUT_READBACK_EN
  logic dout_q, dout_d;

  // Capture the bit falling off the shadow MSB on each shift.
  always_comb begin
    if (shift_s) begin
      dout_d = shadow_q[TB-1];
    end else begin
      dout_d = dout_q;
    end
  end

  // Readback register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= 1'b0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;
`else
  assign dout = 1'b0;
`endif

  assign commit_pulse = commit_q;
  assign tgt          = tgt_q;
  assign shadow       = shadow_q;
  assign frame_err    = err_q;

endmodule

// File: rtl/banked_serial_lut.sv
// Banked serially-loaded LUT: bank array, loaded flags and registered lookup.
// Define BANKED_SERIAL_LUT_READBACK_EN to enable shadow readback on dout.
module banked_serial_lut
  import banked_serial_lut_pkg::*;
#(
  parameter int IN_WIDTH  = 3,
  parameter int OUT_WIDTH = 8,
  parameter int BANKS     = 2,
  localparam int TB       = table_bits(IN_WIDTH, OUT_WIDTH),
  localparam int BANK_W   = bank_idx_w(BANKS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cs_n,
  input  logic                 d,
  input  logic [BANK_W-1:0]    wr_bank,
  input  logic [IN_WIDTH-1:0]  sel,
  input  logic [BANK_W-1:0]    rd_bank,
  output logic [OUT_WIDTH-1:0] out,
  output logic [BANKS-1:0]     loaded,
  output logic                 frame_err,
  output logic                 dout
);

  logic              commit_s;
  logic [BANK_W-1:0] tgt_s;
  logic [TB-1:0]     shadow_s;
  logic              rd_ok_s;

  logic [TB-1:0]        bank_q [BANKS];
  logic [TB-1:0]        bank_d [BANKS];
  logic [BANKS-1:0]     loaded_q, loaded_d;
  logic [OUT_WIDTH-1:0] out_q, out_d;

  serial_frame_rx #(
    .IN_WIDTH (IN_WIDTH),
    .OUT_WIDTH(OUT_WIDTH),
    .BANKS    (BANKS)
  ) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .cs_n        (cs_n),
    .d           (d),
    .wr_bank     (wr_bank),
    .commit_pulse(commit_s),
    .tgt         (tgt_s),
    .shadow      (shadow_s),
    .frame_err   (frame_err),
    .dout        (dout)
  );

  if (BANKS == (1 << BANK_W)) begin : g_rd_full
    assign rd_ok_s = 1'b1;
  end else begin : g_rd_part
    assign rd_ok_s = (rd_bank < BANK_W'(BANKS));
  end

  // Whole-frame bank update on the commit cycle, so lookups never see a partial table.
  always_comb begin
    for (int b = 0; b < BANKS; b++) begin
      if (commit_s && (tgt_s == BANK_W'(b))) begin
        bank_d[b]   = shadow_s;
        loaded_d[b] = 1'b1;
      end else begin
        bank_d[b]   = bank_q[b];
        loaded_d[b] = loaded_q[b];
      end
    end
  end

  // Lookup mux; out-of-range banks read as zero.
  always_comb begin
    if (rd_ok_s) begin
      out_d = bank_q[rd_bank][int'(sel) * OUT_WIDTH +: OUT_WIDTH];
    end else begin
      out_d = {OUT_WIDTH{1'b0}};
    end
  end

  // Bank storage, loaded flags and lookup register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < BANKS; b++) begin
        bank_q[b] <= {TB{1'b0}};
      end
      loaded_q <= {BANKS{1'b0}};
      out_q    <= {OUT_WIDTH{1'b0}};
    end else begin
      for (int b = 0; b < BANKS; b++) begin
        bank_q[b] <= bank_d[b];
      end
      loaded_q <= loaded_d;
      out_q    <= out_d;
    end
  end

  assign out    = out_q;
  assign loaded = loaded_q;

endmodule

// File: tb/tb_banked_serial_lut.sv
// Directed self-checking bench for banked_serial_lut at default parameters.
// Readback checks follow BANKED_SERIAL_LUT_READBACK_EN.
module tb_banked_serial_lut;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_n;
  logic       d;
  logic [0:0] wr_bank;
  logic [2:0] sel;
  logic [0:0] rd_bank;
  logic [7:0] out;
  logic [1:0] loaded;
  logic       frame_err;
  logic       dout;

  int vec_cnt = 0;
  int err_cnt = 0;

`ifdef BANKED_SERIAL_LUT_READBACK_EN
  localparam bit RB_EN = 1'b1;
`else
  localparam bit RB_EN = 1'b0;
`endif

  banked_serial_lut dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs_n     (cs_n),
    .d        (d),
    .wr_bank  (wr_bank),
    .sel      (sel),
    .rd_bank  (rd_bank),
    .out      (out),
    .loaded   (loaded),
    .frame_err(frame_err),
    .dout     (dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:0] rd;
    logic [2:0] sel;
    logic [7:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] make_pat(input logic [7:0] base);
    logic [63:0] p;
    for (int i = 0; i < 8; i++) p[i*8 +: 8] = base + 8'(i);
    return p;
  endfunction

  // Shifts data[nbits-1] first; leaves cs_n low. Optionally checks out each cycle.
  task automatic send_bits(input logic [0:0] bank, input logic [64:0] data, input int nbits,
                           input bit chk, input logic [7:0] exp);
    for (int i = nbits - 1; i >= 0; i--) begin
      @(negedge clk);
      if (chk) check("concurrent_rd", {56'd0, out}, {56'd0, exp});
      cs_n    = 1'b0;
      d       = data[i];
      wr_bank = bank;
    end
  endtask

  task automatic end_frame();
    @(negedge clk);
    cs_n = 1'b1;
    d    = 1'b0;
  endtask

  vec_t vecs[8];
  logic [63:0] pat_a, pat_b, pat_d, pat_p, pat_q;

  initial begin
    pat_a = make_pat(8'hA0);
    pat_b = make_pat(8'h10);
    pat_d = make_pat(8'hC0);
    pat_p = make_pat(8'h5A);
    pat_q = make_pat(8'h33);
    vecs[0] = '{1'b0, 3'd0, 8'h10};
    vecs[1] = '{1'b0, 3'd7, 8'h17};
    vecs[2] = '{1'b0, 3'd4, 8'h14};
    vecs[3] = '{1'b1, 3'd0, 8'hA0};
    vecs[4] = '{1'b1, 3'd7, 8'hA7};
    vecs[5] = '{1'b1, 3'd5, 8'hA5};
    vecs[6] = '{1'b0, 3'd1, 8'h11};
    vecs[7] = '{1'b1, 3'd2, 8'hA2};

    rst_n = 1'b0; cs_n = 1'b1; d = 1'b0; wr_bank = 1'b0; sel = 3'd0; rd_bank = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out", {56'd0, out}, 64'd0);
    check("rst_loaded", {62'd0, loaded}, 64'd0);
    check("rst_err", {63'd0, frame_err}, 64'd0);
    check("rst_dout", {63'd0, dout}, 64'd0);
    rst_n = 1'b1;

    // Reset in the middle of a frame.
    send_bits(1'b0, {1'b0, pat_a}, 30, 1'b0, 8'h00);
    @(negedge clk);
    #2 rst_n = 1'b0; cs_n = 1'b1;
    #1;
    check("midrst_loaded", {62'd0, loaded}, 64'd0);
    check("midrst_err", {63'd0, frame_err}, 64'd0);
    check("midrst_out", {56'd0, out}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_loaded2", {62'd0, loaded}, 64'd0);

    // Short frame to bank 0.
    send_bits(1'b0, {1'b0, pat_a}, 63, 1'b0, 8'h00);
    end_frame();
    @(negedge clk);
    check("short_err", {63'd0, frame_err}, 64'd1);
    check("short_loaded", {62'd0, loaded}, 64'd0);
    rd_bank = 1'b0; sel = 3'd0;
    @(negedge clk);
    check("short_bank0", {56'd0, out}, 64'd0);

    // Valid frame to bank 0 clears frame_err at the commit edge.
    send_bits(1'b0, {1'b0, pat_b}, 64, 1'b0, 8'h00);
    end_frame();
    @(negedge clk);
    check("b0_err_at_c", {63'd0, frame_err}, 64'd1);
    check("b0_loaded_at_c", {62'd0, loaded}, 64'd0);
    @(negedge clk);
    check("b0_err_clr", {63'd0, frame_err}, 64'd0);
    check("b0_loaded", {62'd0, loaded}, 64'd1);
    rd_bank = 1'b0; sel = 3'd6;

    // Bank 1 load while bank 0 is read continuously; then old/new switch at C+2.
    send_bits(1'b1, {1'b0, pat_a}, 64, 1'b1, 8'h16);
    end_frame();
    rd_bank = 1'b1; sel = 3'd3;
    @(negedge clk);
    check("b1_out_c", {56'd0, out}, 64'd0);
    check("b1_loaded_c", {62'd0, loaded}, 64'd1);
    @(negedge clk);
    check("b1_out_c1", {56'd0, out}, 64'd0);
    check("b1_loaded_c1", {62'd0, loaded}, 64'd3);
    @(negedge clk);
    check("b1_out_c2", {56'd0, out}, 64'hA3);

    // Overlong frame to bank 0.
    send_bits(1'b0, {1'b1, pat_d}, 65, 1'b0, 8'h00);
    end_frame();
    @(negedge clk);
    check("long_err", {63'd0, frame_err}, 64'd1);
    @(negedge clk);
    check("long_loaded", {62'd0, loaded}, 64'd3);

    // Table-driven lookups.
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      rd_bank = vecs[v].rd;
      sel     = vecs[v].sel;
      @(negedge clk);
      check($sformatf("lookup_%0d", v), {56'd0, out}, {56'd0, vecs[v].exp});
    end

    // Readback: load P, then shift Q and watch dout replay P MSB-first.
    send_bits(1'b0, {1'b0, pat_p}, 64, 1'b0, 8'h00);
    end_frame();
    repeat (2) @(negedge clk);
    check("rb_loaded", {62'd0, loaded}, 64'd3);
    check("rb_err", {63'd0, frame_err}, 64'd0);
    for (int i = 63; i >= 0; i--) begin
      @(negedge clk);
      if (i != 63) check($sformatf("dout_%0d", i + 1), {63'd0, dout}, {63'd0, RB_EN & pat_p[i+1]});
      cs_n = 1'b0; d = pat_q[i]; wr_bank = 1'b0;
    end
    @(negedge clk);
    check("dout_0", {63'd0, dout}, {63'd0, RB_EN & pat_p[0]});
    cs_n = 1'b1; d = 1'b0;
    repeat (2) @(negedge clk);
    rd_bank = 1'b0; sel = 3'd2;
    @(negedge clk);
    check("rb_bank0", {56'd0, out}, 64'h35);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
